// File: rtl/kf_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kf_fixed_pkg
//  Description : Shared fixed-point definitions for the Kalman datapath
//                (qmult / qdiv_seq): Q-format defaults, divider state
//                encoding and saturation limits at the default word width.
//  Optional    : QDIV_SATURATE_EN (saturating divider results). It is off by
//                default. Enable it either on the tool command line or by
//                un-commenting the define below.
//  Revision    : 1.0 - initial release
// ============================================================================
// `define QDIV_SATURATE_EN

package kf_fixed_pkg;

  localparam int KF_Q = 18;  // fraction bits
  localparam int KF_N = 32;  // total word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } qdiv_state_e;

  // Saturation limits at the default width. Width-generic users rebuild
  // these with the same bit pattern for their own N.
  localparam logic [KF_N-1:0] MAX_POS = {1'b0, {(KF_N-1){1'b1}}};
  localparam logic [KF_N-1:0] MIN_NEG = {1'b1, {(KF_N-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/qdiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : qdiv_step
//  Description : One combinational restoring-division step. It shifts the
//                next numerator bit into the partial remainder, then
//                subtracts the divisor when the trial value allows it.
//  Ports       : rem_i     - partial remainder (kept below div_i)
//                num_bit_i - next numerator bit, MSB first
//                div_i     - divisor magnitude
//                rem_o     - next partial remainder
//                q_bit_o   - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module qdiv_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         num_bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] trial;

  always_comb begin
    trial   = {rem_i, num_bit_i};
    q_bit_o = (trial >= {1'b0, div_i});
    // When the subtraction happens the difference is below div_i, so it
    // always fits back into W bits.
    rem_o   = q_bit_o ? W'(trial - {1'b0, div_i}) : trial[W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/qdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : qdiv_seq
//  Description : Sequential signed Q-format divider. It does restoring
//                division and produces one quotient bit per clock (N+Q
//                cycles). It has valid/ready handshakes on the operand side
//                and on the result side.
//  Optional    : QDIV_SATURATE_EN - when it is defined, the result clamps to
//                the representable range on overflow and on divide-by-zero.
//                Otherwise the result wraps on overflow and is 0 on
//                divide-by-zero. ovr behaves the same in both builds.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid / in_ready - operand handshake (a, b)
//                out_valid/out_ready - result handshake (o_result, ovr)
//                ovr                 - overflow or divide-by-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module qdiv_seq
  import kf_fixed_pkg::*;
#(
  parameter int Q = KF_Q,
  parameter int N = KF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] o_result,
  output logic         ovr
);

  localparam int            W        = N + Q;
  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_NEG  = {1'b1, {(N-1){1'b0}}};
  // Quotient magnitude 2^(N-1). This is the only out-of-range magnitude that
  // is still legal when the result is negative.
  localparam logic [W-1:0]  QM_MIN   = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};

`ifdef QDIV_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  qdiv_state_e   state_q, state_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  absb_q, absb_d;
  logic [N-1:0]  rem_q, rem_d;
  // The numerator shifts out of the MSB while quotient bits shift into the
  // LSB. After W steps the register holds the quotient magnitude.
  logic [W-1:0]  nq_q, nq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  result_q, result_d;
  logic          ovr_q, ovr_d;

  logic [N-1:0]  abs_a, abs_b;
  logic [N-1:0]  rem_next;
  logic          q_bit;
  logic [W-1:0]  qm;
  logic          qm_hi_nz;
  logic          overflow;
  logic [N-1:0]  signed_low;
  logic [N-1:0]  calc_result;

  qdiv_step #(.W(N)) u_step (
    .rem_i     (rem_q),
    .num_bit_i (nq_q[W-1]),
    .div_i     (absb_q),
    .rem_o     (rem_next),
    .q_bit_o   (q_bit)
  );

  always_comb begin
    // -2^(N-1) maps onto the unsigned value 2^(N-1).
    abs_a       = a[N-1] ? (N'(0) - a) : a;
    abs_b       = b[N-1] ? (N'(0) - b) : b;
    qm          = {nq_q[W-2:0], q_bit};
    qm_hi_nz    = |qm[W-1:N-1];
    overflow    = sign_q ? (qm_hi_nz && (qm != QM_MIN)) : qm_hi_nz;
    signed_low  = sign_q ? (N'(0) - qm[N-1:0]) : qm[N-1:0];
    calc_result = (SATURATE && overflow) ? (sign_q ? SAT_NEG : SAT_POS)
                                         : signed_low;
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    absb_d      = absb_q;
    rem_d       = rem_q;
    nq_d        = nq_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovr_d       = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = a[N-1] ^ b[N-1];
          absb_d = abs_b;
          rem_d  = '0;
          nq_d   = {abs_a, {Q{1'b0}}};
          cnt_d  = CNT_LAST;
          if (b == '0) begin
            // Divide-by-zero goes straight to DONE. ovr doubles as the
            // div0 flag. The clamp direction depends only on the sign of a.
            state_d  = ST_DONE;
            ovr_d    = 1'b1;
            result_d = SATURATE ? (a[N-1] ? SAT_NEG : SAT_POS) : '0;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = rem_next;
        nq_d  = qm;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = calc_result;
          ovr_d       = overflow;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        // Only the divide-by-zero path enters DONE with out_valid low. It
        // raises out_valid one cycle after acceptance.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      absb_q      <= '0;
      rem_q       <= '0;
      nq_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      absb_q      <= absb_d;
      rem_q       <= rem_d;
      nq_q        <= nq_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovr_q       <= ovr_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign o_result  = result_q;
  assign ovr       = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_qdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qdiv_seq
//  Description : Self-checking bench for qdiv_seq. It runs directed and
//                random divisions against an arithmetic reference model, and
//                it covers handshake stalls, back-to-back operation and an
//                asynchronous reset in the middle of a division.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qdiv_seq;

  localparam int N   = 32;
  localparam int Q   = 18;
  localparam int LAT = N + Q;
  localparam int TMO = 200;

`ifdef QDIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  o_result;
  logic          ovr;

  int total = 0;
  int bad   = 0;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_result  (o_result),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  // Reference: exact rational quotient truncated toward zero, using wide
  // integer arithmetic.
  function automatic void ref_div(input logic [31:0] ai, input logic [31:0] bi,
                                  output logic [31:0] res, output logic ov);
    longint sa, sb, sq;
    longint unsigned ma, mb, qm;
    bit neg;
    sa  = longint'($signed(ai));
    sb  = longint'($signed(bi));
    neg = (sa < 0) != (sb < 0);
    ma  = (sa < 0) ? longint'(-sa) : longint'(sa);
    mb  = (sb < 0) ? longint'(-sb) : longint'(sb);
    if (mb == 0) begin
      ov  = 1'b1;
      res = SAT ? ((sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;
    end else begin
      qm  = (ma << Q) / mb;
      ov  = neg ? (qm > 64'd2147483648) : (qm > 64'd2147483647);
      sq  = neg ? -longint'(qm) : longint'(qm);
      res = sq[31:0];
      if (SAT && ov) res = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  endfunction

  // Drives one complete transaction. It starts and ends on a falling edge.
  // lat counts rising edges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi,
                        output int lat, output logic [31:0] res, output logic ov,
                        output bit to);
    int w;
    to = 1'b0;
    w  = 0;
    while (!in_ready && w < TMO) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) to = 1'b1;
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) to = 1'b1;
    res = o_result;
    ov  = ovr;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (o_result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", o_result); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic        vo [8];
    logic [31:0] res;
    logic        ov;
    int          lat;
    bit          to;
    va[0] = 32'h0006_0000; vb[0] = 32'h0002_0000; vr[0] = 32'h000C_0000; vo[0] = 1'b0;
    va[1] = 32'hFFFC_0000; vb[1] = 32'h0001_0000; vr[1] = 32'hFFF0_0000; vo[1] = 1'b0;
    va[2] = 32'hFFFC_0000; vb[2] = 32'hFFFC_0000; vr[2] = 32'h0004_0000; vo[2] = 1'b0;
    va[3] = 32'hFFFC_0000; vb[3] = 32'h000C_0000; vr[3] = 32'hFFFE_AAAB; vo[3] = 1'b0;
    va[4] = 32'h7FFF_FFFF; vb[4] = 32'h0000_0001; vr[4] = SAT ? 32'h7FFF_FFFF : 32'hFFFC_0000; vo[4] = 1'b1;
    // -2^13 / 2^0 = -2^13: the most negative representable result, not an overflow.
    va[5] = 32'h8000_0000; vb[5] = 32'h0004_0000; vr[5] = 32'h8000_0000; vo[5] = 1'b0;
    // -2^13 / -1 = +2^13: just out of range on the positive side.
    va[6] = 32'h8000_0000; vb[6] = 32'hFFFC_0000; vr[6] = SAT ? 32'h7FFF_FFFF : 32'h8000_0000; vo[6] = 1'b1;
    va[7] = 32'h0000_0000; vb[7] = 32'hFFFF_FFFF; vr[7] = 32'h0000_0000; vo[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], lat, res, ov, to);
      total++; if (to) begin bad++; $display("FAIL directed_timeout[%0d]: got timeout want completion", i); end
      total++; if (res !== vr[i]) begin bad++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, vr[i]); end
      total++; if (ov !== vo[i]) begin bad++; $display("FAIL directed_ovr[%0d]: got %b want %b", i, ov, vo[i]); end
      total++; if (lat != LAT) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_div0();
    logic [31:0] va [3];
    logic [31:0] vr [3];
    logic [31:0] res;
    logic        ov;
    int          lat;
    bit          to;
    va[0] = 32'hFFFC_0000; vr[0] = SAT ? 32'h8000_0000 : 32'h0;
    va[1] = 32'h0006_0000; vr[1] = SAT ? 32'h7FFF_FFFF : 32'h0;
    va[2] = 32'h0000_0000; vr[2] = SAT ? 32'h7FFF_FFFF : 32'h0;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], 32'h0, lat, res, ov, to);
      total++; if (to) begin bad++; $display("FAIL div0_timeout[%0d]: got timeout want completion", i); end
      total++; if (res !== vr[i]) begin bad++; $display("FAIL div0_result[%0d]: got %h want %h", i, res, vr[i]); end
      total++; if (ov !== 1'b1) begin bad++; $display("FAIL div0_ovr[%0d]: got %b want 1", i, ov); end
      total++; if (lat != 1) begin bad++; $display("FAIL div0_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, res, er;
    logic        ov, eo;
    int          lat;
    bit          to;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom >> $urandom_range(0, 31);
        2: ra = 32'h8000_0000;
        default: ra = 32'h0 - ($urandom >> $urandom_range(8, 31));
      endcase
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 64) - 32'd32;
        2: rb = $urandom >> $urandom_range(0, 31);
        3: rb = 32'h0 - ($urandom >> $urandom_range(4, 31));
        default: rb = $urandom >> 12;
      endcase
      ref_div(ra, rb, er, eo);
      run_op(ra, rb, lat, res, ov, to);
      total++; if (to) begin bad++; $display("FAIL random_timeout[%0d]: got timeout want completion", i); end
      total++; if (res !== er) begin bad++; $display("FAIL random_result[%0d] a=%h b=%h: got %h want %h", i, ra, rb, res, er); end
      total++; if (ov !== eo) begin bad++; $display("FAIL random_ovr[%0d] a=%h b=%h: got %b want %b", i, ra, rb, ov, eo); end
      total++; if (lat != ((rb == 32'h0) ? 1 : LAT)) begin bad++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, (rb == 32'h0) ? 1 : LAT); end
    end
  endtask

  task automatic test_handshake();
    int lat;
    a = 32'h0006_0000; b = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TMO) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat != LAT) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, LAT); end
    // Result held while the consumer stalls; new operands are ignored.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom | 32'h1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (o_result !== 32'h000C_0000) begin bad++; $display("FAIL stall_result[%0d]: got %h want 000c0000", i, o_result); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      @(posedge clk);
      @(negedge clk);
    end
    // Output handshake at t1, with next operands already presented.
    a = 32'hFFFC_0000; b = 32'h000C_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept: got in_ready=%b want 0", in_ready); end
    // out_ready held high: the result is taken on the first DONE edge.
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < TMO) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat != LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    total++; if (o_result !== 32'hFFFE_AAAB) begin bad++; $display("FAIL b2b_result: got %h want fffeaaab", o_result); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL auto_accept: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        ov;
    int          lat;
    bit          to;
    // Leave a nonzero result with ovr set, so that the reset has something to clear.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, lat, res, ov, to);
    a = 32'h0006_0000; b = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_busy: got in_ready=%b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    total++; if (o_result !== 32'h0) begin bad++; $display("FAIL mid_reset_result: got %h want 00000000", o_result); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL mid_reset_ovr: got %b want 0", ovr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h0006_0000, 32'h0002_0000, lat, res, ov, to);
    total++; if (to) begin bad++; $display("FAIL post_reset_timeout: got timeout want completion"); end
    total++; if (res !== 32'h000C_0000) begin bad++; $display("FAIL post_reset_result: got %h want 000c0000", res); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL post_reset_ovr: got %b want 0", ov); end
    total++; if (lat != LAT) begin bad++; $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div0();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
